bram_port_arbiter: RTL
======================

# bram_port_arbiter

Two-requester arbiter that shares one port of the team's dual-port M10K BRAM wrapper (`dp_bram`) between independent masters, e.g. the tile loader writing operands and the compute engine reading them. It grants one request per cycle using round-robin priority, with an optional burst lock. It drives the BRAM port fields directly and tracks in-flight reads through a fixed-latency tag pipeline. Each read response returns only to the requester that issued it.

## Interface
Parameters:
- `W`, 128: data width; must be a multiple of 8.
- `AW`, 10: address width.
- `RD_LAT`, 2: BRAM read latency in cycles, from accept to data at `m_dout`. This is 2 for `dp_bram` with its output register.

Ports (x = 0, 1), one clock, synchronous active-high reset:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  request valid.
- `rx_ready`  out  1  request accepted this cycle.
- `rx_we`  in  1  1 = write, 0 = read.
- `rx_lock`  in  1  keep the grant after this transfer.
- `rx_addr`  in  AW  word address.
- `rx_din`  in  W  write data.
- `rx_be`  in  W/8  byte enables.
- `rx_rvalid`  out  1  read data valid for requester x.
- `rx_rdata`  out  W  read data; zero when `rx_rvalid` = 0.
- `m_en`  out  1  BRAM port enable.
- `m_we`  out  1  BRAM write enable.
- `m_addr`  out  AW  BRAM address.
- `m_din`  out  W  BRAM write data.
- `m_be`  out  W/8  BRAM byte enables.
- `m_dout`  in  W  BRAM read data (registered output).

## Operation
- **State machine `st`:** {IDLE, LOCK0, LOCK1}. A round-robin pointer `prio` (0 or 1) selects which requester wins when both are valid.
- **IDLE:**
  - If only one requester is valid, that requester is granted.
  - If both are valid, requester `prio` is granted.
  - After a grant to requester g, `prio` becomes 1-g.
- **LOCKg:** only requester g can be granted. The other requester's `ready` stays 0 even when requester g is idle.
- **Transitions on a grant to requester g:**
  - `rg_lock` = 1: next state is LOCKg.
  - `rg_lock` = 0: next state is IDLE.
  - The state does not change in a cycle with no grant.
- **Transfer:** `rx_ready` = 1 only for the granted requester. A transfer is `rx_valid & rx_ready`.
- **BRAM drive:**
  - On a transfer, `m_en` = 1 and `m_we`, `m_addr`, `m_din`, `m_be` are the granted requester's fields, combinationally.
  - With no transfer, `m_en` = 0, `m_we` = 0, `m_be` = 0, and `m_addr`/`m_din` hold their last values.
- **Read tracking:**
  - Each accepted read pushes {1, id} into an `RD_LAT`-deep tag shift register.
  - A write or an idle cycle pushes {0, x}.
  - At the tail of the register, `r<id>_rvalid` = 1 and `r<id>_rdata` = `m_dout`.
- **Response back-pressure:** none. Each requester must accept a response in the cycle `rvalid` is high.
- **Ordering:** responses to one requester come back in issue order. Back-to-back reads, including alternating between requesters, sustain one read per cycle.
- **Write visibility:** a read issued after a write to the same address returns the new data. The port runs in NO_CHANGE mode, so the write itself produces no response.

## Timing
- **Reset values:** all `rx_ready`, `rx_rvalid`, `m_en`, `m_we` are 0; `rx_rdata`, `m_addr`, `m_din`, `m_be` are 0. `st` = IDLE, `prio` = 0, all tag stages are invalid.
- **Read latency:** a read accepted in cycle c produces `rx_rvalid` in cycle c+`RD_LAT`.
- **Throughput:** one grant per cycle, with zero bubbles between grants.
- **Combinational path:** `ready` depends on `valid` within the same cycle. `valid` must not depend on `ready`.
- **Reset mid-operation:** the tag pipeline is flushed, so no `rvalid` appears for reads issued before reset. Any lock is released. The BRAM contents are untouched.
- **Lock holder drops valid:** the lock is held indefinitely. The holder must eventually issue a transfer with `lock` = 0 to release it.
- **Simultaneous valid in IDLE:** exactly one grant. Strict alternation under continuous contention.

## Configuration
- **`BRAM_ARB_FIXED_PRIO_EN` defined:** `prio` is fixed at 0, so requester 0 wins every IDLE contention. The round-robin pointer is not built. Lock behaviour is unchanged.
- **Undefined (default):** round-robin as described in Operation.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both requesters valid -> all outputs 0, no grant. In the first cycle after reset with both valid, requester 0 is granted.
- **Contention:** r0 and r1 continuously valid with reads to 0x10 and 0x20 -> grants alternate 0,1,0,1. `r0_rvalid` and `r1_rvalid` alternate starting at cycle `RD_LAT`, with the correct data for each address.
- **Write then read:** r0 writes 0xA5 to byte 0 of address 5 with `be` = 1. Next cycle r1 reads address 5 -> `r1_rdata[7:0]` = 0xA5 two cycles later, other bytes unchanged, no `r0_rvalid`.
- **Lock:** r1 issues 4 writes with `lock` = 1,1,1,0 while r0 stays valid -> r0 is starved for exactly 4 cycles, then granted in the next cycle.
- **Reset mid-flight:** r0 read accepted, `rst` pulsed in the following cycle -> `r0_rvalid` never rises for that read.
- **Fixed priority:** `BRAM_ARB_FIXED_PRIO_EN` defined, both requesters valid for 5 cycles -> r0 is granted all 5 cycles.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Purpose: one requester's request/response bundle into bram_port_arbiter.
// Latency: none, wires only; read data returns RD_LAT cycles after accept.
// Backpressure: ready on requests only; responses cannot be stalled.
//
// Signals:
//   valid/ready      request handshake (transfer = valid & ready)
//   we, lock         1 = write / 0 = read; keep the grant after this transfer
//   addr, din, be    word address, write data, byte enables
//   rvalid, rdata    read response; rdata is zero while rvalid is low
// Modports: master = requester side, slave = arbiter side.
interface bram_port_arbiter_if #(
   parameter int W  = 128,
   parameter int AW = 10
);
   logic           valid;
   logic           ready;
   logic           we;
   logic           lock;
   logic [AW-1:0]  addr;
   logic [W-1:0]   din;
   logic [W/8-1:0] be;
   logic           rvalid;
   logic [W-1:0]   rdata;

   modport master (
      output valid, we, lock, addr, din, be,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, we, lock, addr, din, be,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Purpose: shares one dp_bram port between two requesters (round-robin + burst lock).
// Latency: request-to-BRAM combinational; read data back after RD_LAT cycles.
// Backpressure: ready per requester from grant; no response backpressure.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   r0, r1              requester bundles (bram_port_arbiter_if.slave)
//   m_en, m_we, m_addr, m_din, m_be   BRAM port drive
//   m_dout              BRAM registered read data
// Build option: define BRAM_ARB_FIXED_PRIO_EN to make requester 0 win every
// IDLE contention (round-robin pointer not built). Default is round-robin.
module bram_port_arbiter #(
   parameter int W      = 128,
   parameter int AW     = 10,
   parameter int RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   bram_port_arbiter_if.slave   r0,
   bram_port_arbiter_if.slave   r1,
   output logic                 m_en,
   output logic                 m_we,
   output logic [AW-1:0]        m_addr,
   output logic [W-1:0]         m_din,
   output logic [W/8-1:0]       m_be,
   input  logic [W-1:0]         m_dout
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOCK0 = 2'd1;
   localparam logic [1:0] ST_LOCK1 = 2'd2;

   logic [1:0]      st;
   logic            prio;
   logic            gnt0;
   logic            gnt1;
   logic            xfer;
   logic            sel;
   logic            g_we;
   logic            g_lock;
   logic [AW-1:0]   g_addr;
   logic [W-1:0]    g_din;
   logic [W/8-1:0]  g_be;
   logic [AW-1:0]   addr_q;
   logic [W-1:0]    din_q;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_id;
   logic            tail_v;
   logic            tail_id;

   // Grants already include valid, so gnt0|gnt1 is the transfer itself.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         case (st)
            ST_LOCK0: gnt0 = r0.valid;
            ST_LOCK1: gnt1 = r1.valid;
            default: begin
               // r0 wins alone, or on contention when the pointer favours it
               if (r0.valid && (!r1.valid || !prio))
                  gnt0 = 1'b1;
               else if (r1.valid)
                  gnt1 = 1'b1;
            end
         endcase
      end
   end

   assign r0.ready = gnt0;
   assign r1.ready = gnt1;
   assign xfer     = gnt0 | gnt1;
   assign sel      = gnt1;

   assign g_we   = sel ? r1.we   : r0.we;
   assign g_lock = sel ? r1.lock : r0.lock;
   assign g_addr = sel ? r1.addr : r0.addr;
   assign g_din  = sel ? r1.din  : r0.din;
   assign g_be   = sel ? r1.be   : r0.be;

   // Address/data hold their last transferred values when the port is idle.
   assign m_en   = xfer;
   assign m_we   = xfer & g_we;
   assign m_addr = xfer ? g_addr : addr_q;
   assign m_din  = xfer ? g_din  : din_q;
   assign m_be   = xfer ? g_be   : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= ST_IDLE;
         addr_q <= '0;
         din_q  <= '0;
         tag_v  <= '0;
         tag_id <= '0;
      end else begin
         if (xfer) begin
            st     <= g_lock ? (sel ? ST_LOCK1 : ST_LOCK0) : ST_IDLE;
            addr_q <= g_addr;
            din_q  <= g_din;
         end
         // Tag pipeline mirrors BRAM read latency; stage 0 is the newest.
         tag_v[0]  <= xfer & ~g_we;
         tag_id[0] <= sel;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

`ifdef BRAM_ARB_FIXED_PRIO_EN
   assign prio = 1'b0;
`else
   // After a grant to g, the other requester gets priority next contention.
   always_ff @(posedge clk) begin
      if (rst)
         prio <= 1'b0;
      else if (xfer)
         prio <= ~sel;
   end
`endif

   // Gate with rst so nothing issued before a reset can surface during it.
   assign tail_v  = tag_v[RD_LAT-1] & ~rst;
   assign tail_id = tag_id[RD_LAT-1];

   assign r0.rvalid = tail_v & ~tail_id;
   assign r1.rvalid = tail_v &  tail_id;
   assign r0.rdata  = r0.rvalid ? m_dout : '0;
   assign r1.rdata  = r1.rvalid ? m_dout : '0;

endmodule
